// File: rtl/led_fade_pwm.sv
// Multi-channel LED PWM driver with an autonomous per-channel brightness sequencer.
// Latency: LED/PWM_CLK/VAL_CLK are registered, one CLK after the counter state that produces them.
// Backpressure: none; EN=0 freezes every counter and brightness state and forces the outputs low.
//
// Ports:
//   CLK          system clock
//   RST          synchronous reset, active-high, overrides EN
//   EN           run enable
//   MODE         0=sawtooth, 1=triangle (breathing), 2=static, 3=hold
//   STATIC_DUTY  per-channel static duty, channel i at [i*W +: W], clamped to TOP
//   LED          PWM outputs, one per channel
//   PWM_CLK      one-CLK pulse per PWM period
//   VAL_CLK      one-CLK pulse per brightness update
module led_fade_pwm #(
  parameter int CH       = 3,
  parameter int W        = 8,
  parameter int TOP      = 124,
  parameter int PSC      = 24,
  parameter int STEP_DIV = 9
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [1:0]        MODE,
  input  logic [CH*W-1:0]   STATIC_DUTY,
  output logic [CH-1:0]     LED,
  output logic              PWM_CLK,
  output logic              VAL_CLK
);

  // A zero-valued divider still needs a one-bit counter.
  localparam int PSC_W  = (PSC > 0) ? $clog2(PSC + 1) : 1;
  localparam int STEP_W = (STEP_DIV > 0) ? $clog2(STEP_DIV + 1) : 1;

  localparam logic [PSC_W-1:0]  PSC_V  = PSC_W'(PSC);
  localparam logic [STEP_W-1:0] STEP_V = STEP_W'(STEP_DIV);
  localparam logic [W-1:0]      TOP_V  = W'(TOP);

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_STATIC = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  // Channels start spread evenly across the brightness range so a
  // freshly reset board shows distinct levels on every LED.
  function automatic logic [W-1:0] init_b(input int idx);
    return W'(((TOP + 1) * (idx + 1)) / (CH + 1));
  endfunction

  // Counters
  logic [PSC_W-1:0]  psc_cnt_q,  psc_cnt_d;
  logic [W-1:0]      pwm_cnt_q,  pwm_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

  // Per-channel brightness engine state.
  // dir: 0 = counting up, 1 = counting down (triangle mode only).
  logic [CH-1:0][W-1:0] b_q,   b_d;
  logic [CH-1:0]        dir_q, dir_d;
  logic [CH-1:0][W-1:0] dty_q, dty_d;

  // Registered outputs
  logic [CH-1:0] led_q, led_d;
  logic          pwm_clk_q;
  logic          val_clk_q;

  // Static duty per channel after clamping to the brightness range.
  logic [CH-1:0][W-1:0] static_val;

  logic  tick;
  logic  boundary;
  logic  update;
  mode_e mode;

  assign mode     = mode_e'(MODE);
  assign tick     = EN && (psc_cnt_q == PSC_V);
  assign boundary = tick && (pwm_cnt_q == TOP_V);
  assign update   = boundary && (step_cnt_q == STEP_V);

  always_comb begin
    static_val = '0;
    for (int i = 0; i < CH; i++) begin
      static_val[i] = (STATIC_DUTY[i*W +: W] > TOP_V) ? TOP_V : STATIC_DUTY[i*W +: W];
    end
  end

  // Timebase: prescaler -> PWM counter -> step divider.
  always_comb begin
    psc_cnt_d  = psc_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    step_cnt_d = step_cnt_q;

    if (tick) begin
      psc_cnt_d = '0;
    end else if (EN) begin
      psc_cnt_d = psc_cnt_q + PSC_W'(1);
    end

    if (boundary) begin
      pwm_cnt_d = '0;
    end else if (tick) begin
      pwm_cnt_d = pwm_cnt_q + W'(1);
    end

    if (boundary) begin
      step_cnt_d = (step_cnt_q == STEP_V) ? '0 : step_cnt_q + STEP_W'(1);
    end
  end

  // Brightness engine and duty latch.
  // dty is reloaded only at a period boundary, so the compare below never
  // sees a duty change mid-period and the LED cannot glitch. When an update
  // coincides with the boundary, dty takes the pre-update b (the new b shows
  // one period later), except in static mode where the clamped static value
  // goes straight into dty.
  always_comb begin
    b_d   = b_q;
    dir_d = dir_q;
    dty_d = dty_q;
    led_d = '0;

    for (int i = 0; i < CH; i++) begin
      if (boundary) begin
        dty_d[i] = (mode == MODE_STATIC) ? static_val[i] : b_q[i];
      end

      if (update) begin
        case (mode)
          MODE_SAW: begin
            b_d[i] = (b_q[i] == TOP_V) ? '0 : b_q[i] + W'(1);
          end
          MODE_TRI: begin
            if (!dir_q[i]) begin
              if (b_q[i] == TOP_V) begin
                b_d[i]   = TOP_V - W'(1);
                dir_d[i] = 1'b1;
              end else begin
                b_d[i] = b_q[i] + W'(1);
              end
            end else begin
              if (b_q[i] == '0) begin
                b_d[i]   = W'(1);
                dir_d[i] = 1'b0;
              end else begin
                b_d[i] = b_q[i] - W'(1);
              end
            end
          end
          MODE_STATIC: begin
            // dir is deliberately left alone so a return to triangle mode
            // keeps breathing in the direction it was going.
            b_d[i] = static_val[i];
          end
          default: begin
            // MODE_HOLD: freeze brightness and direction.
            b_d[i] = b_q[i];
          end
        endcase
      end

      led_d[i] = EN && (pwm_cnt_q < dty_q[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      psc_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      for (int i = 0; i < CH; i++) begin
        b_q[i] <= init_b(i);
      end
      dir_q     <= '0;
      dty_q     <= '0;
      led_q     <= '0;
      pwm_clk_q <= 1'b0;
      val_clk_q <= 1'b0;
    end else begin
      psc_cnt_q  <= psc_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      b_q        <= b_d;
      dir_q      <= dir_d;
      dty_q      <= dty_d;
      led_q      <= led_d;
      pwm_clk_q  <= boundary;
      val_clk_q  <= update;
    end
  end

  assign LED     = led_q;
  assign PWM_CLK = pwm_clk_q;
  assign VAL_CLK = val_clk_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: two instances, one running every CLK (TOP=3, PSC=0,
// STEP_DIV=0) and one with PSC=2, STEP_DIV=1 for the prescale and step-division paths.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_led_fade_pwm;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with unit prescale
  logic        rst, en;
  logic [1:0]  mode;
  logic [11:0] sdty;
  logic [2:0]  led;
  logic        pwm_clk, val_clk;

  // Instance with PSC=2, STEP_DIV=1
  logic        rst2, en2;
  logic [1:0]  mode2;
  logic [11:0] sdty2;
  logic [2:0]  led2;
  logic        pwm_clk2, val_clk2;

  led_fade_pwm #(.CH(3), .W(4), .TOP(3), .PSC(0), .STEP_DIV(0)) dut (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .STATIC_DUTY(sdty),
    .LED(led), .PWM_CLK(pwm_clk), .VAL_CLK(val_clk)
  );

  led_fade_pwm #(.CH(3), .W(4), .TOP(3), .PSC(2), .STEP_DIV(1)) dut2 (
    .CLK(clk), .RST(rst2), .EN(en2), .MODE(mode2), .STATIC_DUTY(sdty2),
    .LED(led2), .PWM_CLK(pwm_clk2), .VAL_CLK(val_clk2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  string tag_q[$];
  int    exp_q[$];

  // Results of one 4-CLK PWM period window
  int h0, h1, h2, pc, vc, pl, vl;

  int saw_exp[6] = '{0, 1, 2, 3, 0, 1};
  int tri_b[8]   = '{3, 2, 1, 0, 1, 2, 3, 2};

  int pc_pos[$];
  int vc_pos[$];
  int lsum, psum;

  task automatic expect_v(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(input int obs);
    string t;
    int    e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", t, obs, e);
      end
    end
  endtask

  task automatic restart(input logic [1:0] m, input logic [11:0] s);
    rst  = 1'b1;
    en   = 1'b0;
    mode = m;
    sdty = s;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
  endtask

  // Sample one PWM period (TOP+1 = 4 CLK) of the unit-prescale instance.
  task automatic measure_period();
    h0 = 0; h1 = 0; h2 = 0; pc = 0; vc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      h0 += int'(led[0]);
      h1 += int'(led[1]);
      h2 += int'(led[2]);
      pc += int'(pwm_clk);
      vc += int'(val_clk);
    end
    pl = int'(pwm_clk);
    vl = int'(val_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd2; sdty = {4'd9, 4'd0, 4'd2};
    rst2 = 1'b1; en2 = 1'b0; mode2 = 2'd0; sdty2 = '0;

    // ---- Reset state
    expect_v("rst_led", 0);
    expect_v("rst_pwm_clk", 0);
    expect_v("rst_val_clk", 0);
    expect_v("rst_b0", 1);
    expect_v("rst_b1", 2);
    expect_v("rst_b2", 3);
    repeat (2) @(negedge clk);
    chk(int'(led));
    chk(int'(pwm_clk));
    chk(int'(val_clk));
    chk(int'(dut.b_q[0]));
    chk(int'(dut.b_q[1]));
    chk(int'(dut.b_q[2]));

    // ---- Static duty, ch2 clamped from 9 to TOP
    for (int p = 0; p < 2; p++) begin
      expect_v("static_led0_hi", 2);
      expect_v("static_led1_hi", 0);
      expect_v("static_led2_hi", 3);
      expect_v("static_pwm_clk_count", 1);
      expect_v("static_pwm_clk_at_end", 1);
    end
    expect_v("static_b2_clamped", 3);
    rst = 1'b0; en = 1'b1;
    measure_period();
    measure_period();
    for (int p = 0; p < 2; p++) begin
      measure_period();
      chk(h0); chk(h1); chk(h2); chk(pc); chk(pl);
    end
    chk(int'(dut.b_q[2]));

    // ---- Sawtooth: ch0 duty per period
    for (int p = 0; p < 6; p++) begin
      expect_v($sformatf("saw_led0_hi_p%0d", p), saw_exp[p]);
      expect_v($sformatf("saw_val_clk_count_p%0d", p), 1);
      expect_v($sformatf("saw_val_clk_at_end_p%0d", p), 1);
    end
    restart(2'd0, '0);
    for (int p = 0; p < 6; p++) begin
      measure_period();
      chk(h0); chk(vc); chk(vl);
    end

    // ---- Triangle: ch2 brightness walk and the duty it produces
    expect_v("tri_b2_init", tri_b[0]);
    for (int k = 0; k < 7; k++) begin
      expect_v($sformatf("tri_led2_hi_w%0d", k), (k == 0) ? 0 : tri_b[k-1]);
      expect_v($sformatf("tri_b2_w%0d", k), tri_b[k+1]);
    end
    restart(2'd1, '0);
    chk(int'(dut.b_q[2]));
    for (int k = 0; k < 7; k++) begin
      measure_period();
      chk(h2);
      chk(int'(dut.b_q[2]));
    end

    // ---- Enable drop mid-period at pwm_cnt=2
    expect_v("en_led_before_drop", 7);
    expect_v("en_pwm_cnt_at_drop", 2);
    expect_v("en_led_off_next", 0);
    expect_v("en_led_sum_disabled", 0);
    expect_v("en_pwm_clk_disabled", 0);
    expect_v("en_pwm_cnt_held", 2);
    expect_v("en_resume_tick1_pwm_clk", 0);
    expect_v("en_resume_tick2_pwm_clk", 1);
    restart(2'd2, {4'd3, 4'd3, 4'd3});
    measure_period();
    measure_period();
    repeat (2) @(negedge clk);
    chk(int'(led));
    chk(int'(dut.pwm_cnt_q));
    en = 1'b0;
    @(negedge clk);
    chk(int'(led));
    lsum = int'(led);
    psum = int'(pwm_clk);
    repeat (4) begin
      @(negedge clk);
      lsum += int'(led);
      psum += int'(pwm_clk);
    end
    chk(lsum);
    chk(psum);
    chk(int'(dut.pwm_cnt_q));
    en = 1'b1;
    @(negedge clk);
    chk(int'(pwm_clk));
    @(negedge clk);
    chk(int'(pwm_clk));

    // ---- Mode switch triangle -> static -> triangle keeps direction
    expect_v("sw_static_b0", 1);
    expect_v("sw_static_b1", 0);
    expect_v("sw_static_b2", 2);
    expect_v("sw_resume_b0", 2);
    expect_v("sw_resume_b1", 1);
    expect_v("sw_resume_b2", 1);
    restart(2'd1, '0);
    measure_period();
    measure_period();
    mode = 2'd2;
    sdty = {4'd2, 4'd0, 4'd1};
    measure_period();
    chk(int'(dut.b_q[0]));
    chk(int'(dut.b_q[1]));
    chk(int'(dut.b_q[2]));
    mode = 2'd1;
    measure_period();
    chk(int'(dut.b_q[0]));
    chk(int'(dut.b_q[1]));
    chk(int'(dut.b_q[2]));

    // ---- Prescale and step division, then reset between pulses
    expect_v("psc_pwm_clk_count", 4);
    expect_v("psc_pwm_clk_pos0", 12);
    expect_v("psc_pwm_clk_pos1", 24);
    expect_v("psc_pwm_clk_pos2", 36);
    expect_v("psc_pwm_clk_pos3", 48);
    expect_v("psc_val_clk_count", 2);
    expect_v("psc_val_clk_pos0", 24);
    expect_v("psc_val_clk_pos1", 48);
    expect_v("psc_led_before_rst", 3);
    expect_v("psc_b0_before_rst", 3);
    expect_v("psc_rst_led", 0);
    expect_v("psc_rst_pwm_clk", 0);
    expect_v("psc_rst_val_clk", 0);
    expect_v("psc_rst_b0", 1);
    rst2 = 1'b0;
    en2  = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (pwm_clk2) pc_pos.push_back(c);
      if (val_clk2) vc_pos.push_back(c);
    end
    chk(pc_pos.size());
    for (int i = 0; i < 4; i++) chk((i < pc_pos.size()) ? pc_pos[i] : -1);
    chk(vc_pos.size());
    for (int i = 0; i < 2; i++) chk((i < vc_pos.size()) ? vc_pos[i] : -1);
    chk(int'(led2));
    chk(int'(dut2.b_q[0]));
    rst2 = 1'b1;
    @(negedge clk);
    chk(int'(led2));
    chk(int'(pwm_clk2));
    chk(int'(val_clk2));
    chk(int'(dut2.b_q[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Multi-channel LED PWM driver with an autonomous brightness sequencer; the generalised successor to the fixed 3-channel RGB driver.
- A prescaled PWM timer generates CH duty-cycled outputs.
- A per-channel brightness engine updates once every STEP_DIV+1 PWM periods in sawtooth, triangle (breathing) or static mode.
- Sits between the board clock and the LED pins.

Parameters:
- CH, 3, number of LED channels (1..8).
- W, 8, brightness/duty width in bits.
- TOP, 124, PWM counter top value; brightness range 0..TOP; requires 1 <= TOP <= 2^W-1.
- PSC, 24, CLK prescale; the PWM counter ticks once per PSC+1 CLK cycles (0..65535).
- STEP_DIV, 9, brightness updates once per STEP_DIV+1 PWM periods (0..255).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  run enable.
- MODE  in  2  0=sawtooth, 1=triangle, 2=static, 3=hold.
- STATIC_DUTY  in  CH*W  per-channel duty for static mode; channel i = bits [i*W +: W].
- LED  out  CH  PWM outputs.
- PWM_CLK  out  1  one-CLK pulse per PWM period.
- VAL_CLK  out  1  one-CLK pulse per brightness update.

Behaviour:
- Reset, sampled on the CLK edge with RST=1:
  - psc_cnt=0, pwm_cnt=0, step_cnt=0.
  - b[i]=((TOP+1)*(i+1))/(CH+1), integer floor; e.g. 31/62/93 for defaults.
  - dir[i]=up, dty[i]=0.
  - LED=0, PWM_CLK=0, VAL_CLK=0.
  - RST overrides EN and any activity in progress.
- tick: EN=1 and psc_cnt==PSC.
  - On tick, psc_cnt->0; otherwise, when EN=1, psc_cnt+1.
- pwm_cnt: on tick, increments; it wraps TOP->0.
- boundary: tick and pwm_cnt==TOP. At a boundary edge:
  - pwm_cnt->0.
  - dty[i] latches its source: b[i] in modes 0, 1 and 3; min(STATIC_DUTY[i], TOP) in mode 2.
  - step_cnt advances, wrapping STEP_DIV->0.
- update: boundary and step_cnt==STEP_DIV. At an update edge, b[i] changes by MODE:
  - Mode 0: b = (b==TOP) ? 0 : b+1.
  - Mode 1, dir up: b==TOP -> b=TOP-1, dir=down; else b+1.
  - Mode 1, dir down: b==0 -> b=1, dir=up; else b-1.
  - Mode 2: b = min(STATIC_DUTY[i], TOP); dir unchanged.
  - Mode 3: b and dir unchanged.
- Update and dty latch at the same edge: dty takes the pre-update b; the new b appears in the period after next. This does not apply in mode 2, where dty takes the static value directly.
- MODE is sampled only at boundary/update edges. Switching static->fade continues from the last loaded b with the retained dir.
- LED[i] registered: LED[i] <= EN & (pwm_cnt < dty[i]). Outputs are glitch-free because dty changes only at period start.
  - dty=0 gives LED constantly 0.
  - dty=TOP gives LED high for TOP of TOP+1 ticks.
- PWM_CLK <= boundary. VAL_CLK <= update. Both are registered and high for exactly one CLK.
- EN=0:
  - psc_cnt, pwm_cnt, step_cnt, b, dir and dty hold.
  - LED, PWM_CLK and VAL_CLK are 0 from the next edge.
  - Re-assertion resumes from the held counts; there is no restart.
- Widths:
  - psc_cnt: $clog2(PSC+1), minimum 1.
  - pwm_cnt: W.
  - step_cnt: $clog2(STEP_DIV+1), minimum 1.
  - Comparisons are unsigned; no overflow is possible by construction.

Test Plan:
- Reset (bench params CH=3, W=4, TOP=3, PSC=0, STEP_DIV=0): RST high for 2 cycles, then EN=1 -> LED=0, PWM_CLK=0 and VAL_CLK=0 during reset; internal b = 1, 2, 3.
- Static duty: MODE=2, STATIC_DUTY ch0=2, ch1=0, ch2=9 -> PWM_CLK every 4 CLK; after the second boundary, LED0 is high 2 of every 4 cycles, LED1 always 0, LED2 high 3 of 4 (clamped).
- Sawtooth: MODE=0 -> VAL_CLK pulses every 4 CLK; ch0 dty sequence per period 0 (reset), 1, 2, 3, 0, 1; LED0 high-time per period matches.
- Triangle: MODE=1 -> ch2 b sequence 3, 2, 1, 0, 1, 2, 3, 2; no value ever exceeds TOP or goes below 0.
- Enable and mode switch: drop EN mid-period at pwm_cnt=2 for 5 cycles -> LED=0 the next cycle and no PWM_CLK pulses; on re-enable the first PWM_CLK arrives 2 ticks later. Switch MODE 1->2->1 -> fade resumes from the static value with the preserved dir.
- Prescale and step division: PSC=2, STEP_DIV=1 -> PWM_CLK every 12 CLK, VAL_CLK every 24 CLK; RST asserted between pulses -> all outputs 0 at the next edge and b returns to its init value.
